fft4_2d_tile_driver: RTL and testbench

Initiator side of the 4x4 2-D FFT interface: fetches 4x4 complex tiles from block memory, presents each tile to the `fft4_2d` core with a `next` pulse, and captures the result on `next_out`. It then writes each result tile back to block memory. It sits between the image block memory and the 2-D FFT datapath and sequences a run of `num_tiles` tiles per `start`.

---
 rtl/fft_tile_driver_pkg.sv | 23 ++
 rtl/fft_tile_addr_gen.sv | 49 ++++
 rtl/fft4_2d_tile_driver.sv | 150 +++++++++++++++
 tb/tb_fft4_2d_tile_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_tile_driver_pkg.sv
// Shared types for the 4x4 FFT tile driver: FSM states, tile geometry and the
// complex sample layout used by block memory and the fft4_2d core.
package fft_tile_driver_pkg;

  localparam int TILE_DIM   = 4;
  localparam int TILE_WORDS = TILE_DIM * TILE_DIM;

  // Real part in the upper 32 bits, imaginary in the lower 32 bits.
  typedef struct packed {
    logic [31:0] r;
    logic [31:0] i;
  } complex_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

endpackage

// File: rtl/fft_tile_addr_gen.sv
// Tile/word counters and modulo-2^ADDR_WIDTH read/write address generation
// from the bases latched at the start of a run.
module fft_tile_addr_gen #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_bases,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic                  clr_word,
  input  logic                  inc_word,
  input  logic                  inc_tile,
  output logic [4:0]            word,
  output logic [7:0]            tile,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  logic [ADDR_WIDTH-1:0] rd_base_q, wr_base_q;
  logic [ADDR_WIDTH-1:0] rd_off, wr_off;
  logic [3:0]            rd_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_base_q <= '0;
      wr_base_q <= '0;
      tile      <= '0;
      word      <= '0;
    end else if (load_bases) begin
      rd_base_q <= rd_base;
      wr_base_q <= wr_base;
      tile      <= '0;
      word      <= '0;
    end else begin
      if (inc_tile) tile <= tile + 8'd1;
      if (clr_word)      word <= '0;
      else if (inc_word) word <= word + 5'd1;
    end
  end

  // word reaches 16 in the read-latency cycle of LOAD; hold the last address there.
  assign rd_word = word[4] ? 4'hF : word[3:0];
  assign rd_off  = ADDR_WIDTH'({tile, rd_word});
  assign wr_off  = ADDR_WIDTH'({tile, word[3:0]});
  assign rd_addr = rd_base_q + rd_off;
  assign wr_addr = wr_base_q + wr_off;

endmodule

// File: rtl/fft4_2d_tile_driver.sv
// Sequences 4x4 tiles: block memory -> fft4_2d core -> block memory.
// Optional WAIT watchdog enabled by defining FFT_TILE_DRIVER_TIMEOUT_EN.
module fft4_2d_tile_driver
  import fft_tile_driver_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [7:0]            num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [63:0]           mem_rd_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [63:0]           mem_wr_data,
  output complex_t [0:TILE_DIM-1][0:TILE_DIM-1] fft_in,
  output logic                  fft_next,
  input  complex_t [0:TILE_DIM-1][0:TILE_DIM-1] fft_out,
  input  logic                  fft_next_out
);

  state_t state, state_n;
  logic   load_bases, clr_word, inc_word, inc_tile, cap_res, wd_expire, last_tile;
  logic [4:0] word;
  logic [7:0] tile, ntiles_q;
  logic [3:0] cap_idx;
  complex_t [0:TILE_DIM-1][0:TILE_DIM-1] res_buf;

  fft_tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk        (clk),
    .reset      (reset),
    .load_bases (load_bases),
    .rd_base    (rd_base),
    .wr_base    (wr_base),
    .clr_word   (clr_word),
    .inc_word   (inc_word),
    .inc_tile   (inc_tile),
    .word       (word),
    .tile       (tile),
    .rd_addr    (mem_rd_addr),
    .wr_addr    (mem_wr_addr)
  );

  assign last_tile = ({1'b0, tile} + 9'd1) >= {1'b0, ntiles_q};
  // Data in LOAD lags its address by one cycle.
  assign cap_idx   = word[3:0] - 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load_bases = 1'b0;
    clr_word   = 1'b0;
    inc_word   = 1'b0;
    inc_tile   = 1'b0;
    cap_res    = 1'b0;
    unique case (state)
      S_IDLE:
        if (start) begin
          if (num_tiles != 8'd0) begin
            load_bases = 1'b1;
            state_n    = S_LOAD;
          end else begin
            state_n = S_DONE;
          end
        end
      S_LOAD:
        if (word == 5'(TILE_WORDS)) begin
          clr_word = 1'b1;
          state_n  = S_FIRE;
        end else begin
          inc_word = 1'b1;
        end
      S_FIRE: state_n = S_WAIT;
      S_WAIT:
        if (fft_next_out) begin
          cap_res = 1'b1;
          state_n = S_STORE;
        end else if (wd_expire) begin
          state_n = S_IDLE;
        end
      S_STORE:
        if (word[3:0] == 4'(TILE_WORDS - 1)) begin
          clr_word = 1'b1;
          if (last_tile) begin
            state_n = S_DONE;
          end else begin
            inc_tile = 1'b1;
            state_n  = S_LOAD;
          end
        end else begin
          inc_word = 1'b1;
        end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ntiles_q <= '0;
      fft_in   <= '0;
      res_buf  <= '0;
    end else begin
      if (load_bases) ntiles_q <= num_tiles;
      if (state == S_LOAD && word != 5'd0)
        fft_in[cap_idx[3:2]][cap_idx[1:0]] <= complex_t'(mem_rd_data);
      if (cap_res) res_buf <= fft_out;
    end
  end

`ifdef FFT_TILE_DRIVER_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        error_q;

  assign wd_expire = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      wd_cnt  <= (state == S_WAIT) ? wd_cnt + 16'd1 : 16'd0;
      error_q <= (state == S_WAIT) && !fft_next_out && wd_expire;
    end
  end

  assign error = error_q;
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign fft_next    = (state == S_FIRE);
  assign mem_we      = (state == S_STORE);
  assign mem_wr_data = res_buf[word[3:2]][word[1:0]];

endmodule

// File: tb/tb_fft4_2d_tile_driver.sv
// Randomized bench for fft4_2d_tile_driver against a per-run cycle schedule model.
module tb_fft4_2d_tile_driver;
  import fft_tile_driver_pkg::*;

  localparam int AW    = 13;
  localparam int MEMSZ = 1 << AW;

  logic clk = 1'b0;
  logic reset, start;
  logic [AW-1:0] rd_base, wr_base, mem_rd_addr, mem_wr_addr;
  logic [7:0] num_tiles;
  logic busy, done, error, mem_we, fft_next, fft_next_out;
  logic [63:0] mem_rd_data, mem_wr_data;
  complex_t [0:3][0:3] fft_in;
  complex_t [0:3][0:3] fft_out = '0;
  logic resp_pulse = 1'b0;
  logic stray_pulse = 1'b0;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fft4_2d_tile_driver #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_base(rd_base), .wr_base(wr_base),
    .num_tiles(num_tiles), .busy(busy), .done(done), .error(error),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .fft_in(fft_in),
    .fft_next(fft_next), .fft_out(fft_out), .fft_next_out(fft_next_out)
  );

  assign fft_next_out = resp_pulse | stray_pulse;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Block memory: read image (never written) plus a log of everything written.
  logic [63:0] mem  [0:MEMSZ-1];
  logic [63:0] wlog [0:MEMSZ-1];
  int wcount [0:MEMSZ-1];
  int nwrites = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];
  always @(posedge clk) if (mem_we) begin
    wlog[mem_wr_addr]   <= mem_wr_data;
    wcount[mem_wr_addr] <= wcount[mem_wr_addr] + 1;
    nwrites             <= nwrites + 1;
  end

  // Event monitor.
  int n_next = 0, n_done = 0, n_err = 0, next_cyc = 0, done_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (fft_next) begin n_next++; next_cyc = cyc; end
    if (done)     begin n_done++; done_cyc = cyc; end
    if (error)    begin n_err++;  err_cyc  = cyc; end
  end

  // FFT model: echoes the tile w_arr[tile] cycles after fft_next (0 = never).
  int w_arr [0:15];
  int rt = 0, rcnt = 0;
  complex_t [0:3][0:3] held;
  always @(negedge clk) begin
    resp_pulse = 1'b0;
    if (!busy) rt = 0;
    if (rcnt != 0) begin
      rcnt--;
      if (rcnt == 0) begin resp_pulse = 1'b1; fft_out = held; end
    end
    if (fft_next) begin rcnt = w_arr[rt]; held = fft_in; rt++; end
  end

  // Run schedule model: tile t occupies 34+W_t cycles from cycle 1 after start;
  // offsets 0..15 read, 17 fires, 18+W..33+W store; done follows the last tile.
  logic run_valid = 1'b0;
  int start_cyc = 0, run_len = 0;
  logic [AW-1:0] run_rd, run_wr;
  always @(negedge clk) if (run_valid) begin
    int r, t, o, w, k;
    r = cyc - start_cyc;
    if (r >= 1 && r <= run_len) begin
      chk("busy", 64'(busy), 64'(1));
      chk("done", 64'(done), 64'(r == run_len));
      chk("error", 64'(error), 64'(0));
      if (r < run_len) begin
        t = 0; o = r - 1;
        while (o >= 34 + w_arr[t]) begin o -= 34 + w_arr[t]; t++; end
        w = w_arr[t];
        chk("fft_next", 64'(fft_next), 64'(o == 17));
        chk("mem_we", 64'(mem_we), 64'(o >= 18 + w));
        if (o < 16) chk("rd_addr", 64'(mem_rd_addr), 64'(AW'(run_rd + 16 * t + o)));
        if (o == 17)
          for (int i = 0; i < 16; i++)
            chk("fft_in", fft_in[i / 4][i % 4], mem[AW'(run_rd + 16 * t + i)]);
        if (o >= 18 + w) begin
          k = o - 18 - w;
          chk("wr_addr", 64'(mem_wr_addr), 64'(AW'(run_wr + 16 * t + k)));
          chk("wr_data", mem_wr_data, mem[AW'(run_rd + 16 * t + k)]);
        end
      end
    end else if (r > run_len) begin
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_we", 64'(mem_we), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
    end
  end

  task automatic start_run(input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                           input int n, input bit track);
    @(negedge clk);
    rd_base = rb; wr_base = wb; num_tiles = 8'(n); start = 1'b1;
    run_rd = rb; run_wr = wb; start_cyc = cyc;
    run_len = 1;
    for (int t = 0; t < n; t++) run_len += 34 + w_arr[t];
    run_valid = track;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int nd, nn, nw;
    logic [AW-1:0] a0, ea;
    for (int i = 0; i < MEMSZ; i++) mem[i] = {$urandom, $urandom};
    for (int k = 0; k < 16; k++) mem[13'h100 + k] = {32'(k), ~32'(k)};
    reset = 1'b1; start = 1'b0; rd_base = '0; wr_base = '0; num_tiles = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_next", 64'(fft_next), 64'(0));
    chk("rst_rd_addr", 64'(mem_rd_addr), 64'(0));
    chk("rst_wr_addr", 64'(mem_wr_addr), 64'(0));
    chk("rst_wr_data", mem_wr_data, 64'(0));
    for (int i = 0; i < 16; i++) chk("rst_fft_in", fft_in[i / 4][i % 4], 64'(0));
    reset = 1'b0;

    // Single tile, 5-cycle FFT.
    w_arr[0] = 5; nw = nwrites;
    start_run(13'h100, 13'h400, 1, 1'b1);
    repeat (45) @(negedge clk);
    chk("t1_next_cyc", 64'(next_cyc - start_cyc), 64'(18));
    chk("t1_done_cyc", 64'(done_cyc - start_cyc), 64'(40));
    chk("t1_fft_in21", fft_in[2][1], {32'd9, ~32'd9});
    chk("t1_wr5", wlog[13'h405], {32'd5, ~32'd5});
    chk("t1_nwrites", 64'(nwrites - nw), 64'(16));

    // Empty run.
    a0 = mem_rd_addr; nd = n_done;
    start_run(13'h555, 13'h666, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("empty_done_cyc", 64'(done_cyc - start_cyc), 64'(1));
    chk("empty_ndone", 64'(n_done - nd), 64'(1));
    chk("empty_rd_addr", 64'(mem_rd_addr), 64'(a0));

    // Three tiles.
    w_arr[0] = 3; w_arr[1] = 1; w_arr[2] = 7; nn = n_next; nd = n_done;
    start_run(13'h200, 13'h800, 3, 1'b1);
    repeat (run_len + 2) @(negedge clk);
    chk("t3_nnext", 64'(n_next - nn), 64'(3));
    chk("t3_ndone", 64'(n_done - nd), 64'(1));
    for (int k = 0; k < 48; k++) begin
      chk("t3_wcount", 64'(wcount[13'h800 + k]), 64'(1));
      chk("t3_wdata", wlog[13'h800 + k], mem[13'h200 + k]);
    end

    // Read address wrap.
    w_arr[0] = 2;
    start_run(13'h1FF8, 13'h0F00, 1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      ea = (k < 8) ? AW'(13'h1FF8 + k) : AW'(k - 8);
      chk("wrap_rd", 64'(mem_rd_addr), 64'(ea));
      @(negedge clk);
    end
    repeat (run_len) @(negedge clk);

    // Stray fft_next_out during LOAD and stray start during WAIT.
    w_arr[0] = 8; nn = n_next; nd = n_done;
    start_run(13'h300, 13'hA00, 1, 1'b1);
    repeat (4) @(negedge clk);
    stray_pulse = 1'b1;
    @(negedge clk);
    stray_pulse = 1'b0;
    repeat (15) @(negedge clk);
    rd_base = 13'h1234; num_tiles = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (run_len) @(negedge clk);
    chk("stray_nnext", 64'(n_next - nn), 64'(1));
    chk("stray_ndone", 64'(n_done - nd), 64'(1));
    chk("stray_wr3", wlog[13'hA03], mem[13'h303]);

    // Reset in STORE at word 7, then a fresh run.
    w_arr[0] = 4; nw = nwrites;
    start_run(13'h500, 13'hC00, 1, 1'b1);
    repeat (29) @(negedge clk);
    run_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_we", 64'(mem_we), 64'(0));
    chk("mid_rst_wr_addr", 64'(mem_wr_addr), 64'(0));
    chk("mid_rst_rd_addr", 64'(mem_rd_addr), 64'(0));
    chk("mid_rst_wr_data", mem_wr_data, 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_nwrites", 64'(nwrites - nw), 64'(7));
    w_arr[0] = 1;
    start_run(13'h500, 13'hC00, 1, 1'b1);
    repeat (run_len + 1) @(negedge clk);
    chk("after_rst_nwrites", 64'(nwrites - nw), 64'(23));

    // Randomized runs.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int t = 0; t < n; t++) w_arr[t] = $urandom_range(1, 8);
      nd = n_done;
      start_run(AW'($urandom), AW'($urandom), n, 1'b1);
      repeat (run_len + 1) @(negedge clk);
      chk("rand_ndone", 64'(n_done - nd), 64'(1));
    end

`ifdef FFT_TILE_DRIVER_TIMEOUT_EN
    w_arr[0] = 0; nd = n_done; nw = nwrites; nn = n_err;
    start_run(13'h100, 13'h400, 1, 1'b0);
    repeat (40) @(negedge clk);
    chk("wd_nerr", 64'(n_err - nn), 64'(1));
    chk("wd_err_cyc", 64'(err_cyc - start_cyc), 64'(29));
    chk("wd_ndone", 64'(n_done - nd), 64'(0));
    chk("wd_nwrites", 64'(nwrites - nw), 64'(0));
    chk("wd_busy", 64'(busy), 64'(0));
`endif

    run_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
